// File: rtl/icache_refill.sv
// Instruction-cache refill engine: fetches one line as sequential single-beat word reads.
// Optional macro ICACHE_REFILL_CRITICAL_WORD_FIRST_EN starts each fill at the missed word.
module icache_refill #(
    parameter int LINE_WORDS = 16,
    parameter int OFF_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    input  logic [31:0]               req_addr,
    output logic                      line_ready,
    output logic [32*LINE_WORDS-1:0]  line_data,
    output logic                      bus_req_valid,
    output logic [31:0]               bus_req_addr,
    input  logic                      bus_req_ready,
    input  logic                      bus_resp_valid,
    input  logic [31:0]               bus_resp_data
);

    localparam int BASE_LSB = OFF_W + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [31-BASE_LSB:0]   line_base;
    logic [OFF_W-1:0]       offset;
    logic [OFF_W-1:0]       start_offset;
    logic [OFF_W:0]         count;
    logic                   abort;
    logic                   abort_next;
    logic                   accept;
    logic                   store;
    logic                   hold_ok;
    logic                   last_beat;
    logic                   unused_addr_bits;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    assign start_offset = req_addr[BASE_LSB-1:2];
`else
    assign start_offset = '0;
`endif
    assign unused_addr_bits = ^req_addr[BASE_LSB-1:0];

    // The cache must keep presenting the same line for the whole fill.
    assign hold_ok   = (req_valid == 1'b1) && (req_addr[31:BASE_LSB] == line_base);
    assign last_beat = (count == (OFF_W+1)'(LINE_WORDS - 1));

    assign bus_req_addr = {line_base, offset, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            abort <= 1'b0;
        end else begin
            state <= state_next;
            abort <= abort_next;
        end
    end

    always_comb begin
        state_next    = state;
        abort_next    = abort;
        accept        = 1'b0;
        store         = 1'b0;
        line_ready    = 1'b0;
        bus_req_valid = 1'b0;
        case (state)
            IDLE: begin
                abort_next = 1'b0;
                if (req_valid == 1'b1) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                bus_req_valid = 1'b1;
                if (hold_ok) abort_next = abort;
                else         abort_next = 1'b1;
                // A handshake always wins over an abort in the same cycle.
                if (bus_req_ready == 1'b1) begin
                    state_next = WAIT;
                end else if (abort_next) begin
                    state_next = IDLE;
                    abort_next = 1'b0;
                end
            end
            WAIT: begin
                if (hold_ok) abort_next = abort;
                else         abort_next = 1'b1;
                if (bus_resp_valid == 1'b1) begin
                    if (abort_next) begin
                        state_next = IDLE;
                        abort_next = 1'b0;
                    end else begin
                        store      = 1'b1;
                        state_next = last_beat ? DONE : ISSUE;
                    end
                end
            end
            DONE: begin
                line_ready = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_base <= '0;
            offset    <= '0;
            count     <= '0;
            line_data <= '0;
        end else begin
            if (accept) begin
                line_base <= req_addr[31:BASE_LSB];
                offset    <= start_offset;
                count     <= '0;
            end
            if (store) begin
                offset <= offset + 1'b1;
                count  <= count + 1'b1;
            end
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (store && (offset == OFF_W'(i))) line_data[32*i +: 32] <= bus_resp_data;
            end
        end
    end

endmodule
